// File: rtl/uart_cfg_frame_ctl.sv
// uart_cfg_frame_ctl: framed UART byte stream -> config-bus write controller.
//   Decodes SYNC, ADDR (MSB first), DATA (MSB first), optional XOR CSUM; issues one cfg_we_o
//   per good frame, drops frames on rx error, bad checksum or inter-byte timeout.
// Latency: cfg_we_o earliest the cycle after the final byte strobe; held off while cfg_busy_i.
// Backpressure: cfg_busy_i stalls the write indefinitely; bytes arriving meanwhile are dropped.
// Ports:
//   clk_i, reset_ni        clock, synchronous active-low reset
//   rx_dat_i/rx_stb_i      received byte and its one-cycle valid strobe
//   rx_err_i               one-cycle receiver framing error
//   cfg_busy_i             sink not ready
//   cfg_addr_o/cfg_dat_o   write address/data, held until the next accepted frame
//   cfg_we_o               write strobe (combinational on state and cfg_busy_i)
//   frame_err_o            one-cycle pulse when a frame or byte is dropped
//   err_cnt_o              saturating count of frame_err_o pulses
module uart_cfg_frame_ctl #(
  parameter int         ADDR_BYTES  = 1,
  parameter int         DATA_BYTES  = 1,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter int         TIMEOUT_CYC = 30000
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [7:0]              rx_dat_i,
  input  logic                    rx_stb_i,
  input  logic                    rx_err_i,
  input  logic                    cfg_busy_i,
  output logic [8*ADDR_BYTES-1:0] cfg_addr_o,
  output logic [8*DATA_BYTES-1:0] cfg_dat_o,
  output logic                    cfg_we_o,
  output logic                    frame_err_o,
  output logic [7:0]              err_cnt_o
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DW    = 8 * DATA_BYTES;
  localparam int MAXB  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int CNT_W = (MAXB > 1) ? $clog2(MAXB) : 1;
  // Timer only has to reach TIMEOUT_CYC-1 before the frame is dropped.
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CSUM  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    addr_sh_q, addr_sh_d;
  logic [DW-1:0]    dat_sh_q, dat_sh_d;
  logic [7:0]       csum_q, csum_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [AW-1:0]    cfg_addr_q, cfg_addr_d;
  logic [DW-1:0]    cfg_dat_q, cfg_dat_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             we_c;
  logic             ferr_c;
  logic             timeout_hit;

  // The current idle cycle is the TIMEOUT_CYC-th in a row; a strobe this cycle still wins.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TMR_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_sh_d  = addr_sh_q;
    dat_sh_d   = dat_sh_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    cfg_addr_d = cfg_addr_q;
    cfg_dat_d  = cfg_dat_q;
    we_c       = 1'b0;
    ferr_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Noise and receiver errors between frames are ignored.
        if (rx_stb_i && (rx_dat_i == SYNC_BYTE)) begin
          state_d = S_ADDR;
          cnt_d   = '0;
          csum_d  = '0;
          timer_d = '0;
        end
      end

      S_ADDR, S_DATA, S_CSUM: begin
        if (rx_err_i) begin
          // Error beats a coincident byte.
          ferr_c  = 1'b1;
          state_d = S_IDLE;
        end else if (rx_stb_i) begin
          timer_d = '0;
          if (state_q == S_ADDR) begin
            addr_sh_d = (addr_sh_q << 8) | AW'(rx_dat_i);
            csum_d    = csum_q ^ rx_dat_i;
            if (cnt_q == CNT_W'(ADDR_BYTES - 1)) begin
              state_d = S_DATA;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (state_q == S_DATA) begin
            dat_sh_d = (dat_sh_q << 8) | DW'(rx_dat_i);
            csum_d   = csum_q ^ rx_dat_i;
            if (cnt_q == CNT_W'(DATA_BYTES - 1)) begin
              cnt_d = '0;
              if (CHECKSUM_EN) begin
                state_d = S_CSUM;
              end else begin
                state_d    = S_WRITE;
                cfg_addr_d = addr_sh_q;
                cfg_dat_d  = dat_sh_d;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // Checksum byte: compared as data, a SYNC value here does not resync.
            if (rx_dat_i == csum_q) begin
              state_d    = S_WRITE;
              cfg_addr_d = addr_sh_q;
              cfg_dat_d  = dat_sh_q;
            end else begin
              ferr_c  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else if (timeout_hit) begin
          ferr_c  = 1'b1;
          state_d = S_IDLE;
        end else if (TIMEOUT_CYC != 0) begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_WRITE: begin
        we_c = ~cfg_busy_i;
        // Traffic during the write is lost, but the pending write still completes.
        ferr_c = rx_stb_i | rx_err_i;
        if (!cfg_busy_i) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (ferr_c && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_sh_q  <= '0;
      dat_sh_q   <= '0;
      csum_q     <= '0;
      timer_q    <= '0;
      cfg_addr_q <= '0;
      cfg_dat_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_sh_q  <= addr_sh_d;
      dat_sh_q   <= dat_sh_d;
      csum_q     <= csum_d;
      timer_q    <= timer_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_dat_q  <= cfg_dat_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Strobes are suppressed while reset is asserted so a mid-frame reset is silent.
  assign cfg_we_o    = we_c & reset_ni;
  assign frame_err_o = ferr_c & reset_ni;
  assign cfg_addr_o  = cfg_addr_q;
  assign cfg_dat_o   = cfg_dat_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
